control_multiciclo: RTL and testbench
=====================================

// Module: control_multiciclo
// PURPOSE
// Multicycle MIPS main control FSM: the issuing end of the ALU interface. It sequences
//   fetch/decode/execute/memory/writeback for R-type, LW, SW, BEQ, ADDI and J.
// It drives AluOp plus all datapath mux/strobe controls, and waits on a memory ready handshake.
// Sits beside the datapath; AluOp encoding below is binding on both ends.
// PARAMETERS
// TIMEOUT   16   max consecutive MemListo=0 cycles in a wait state before TRAP; 0 = never time out
// PORTS
// clk        in   1  clock, all state on rising edge
// reset      in   1  synchronous, active-high
// Opcode     in   6  IR[31:26], valid from DECODE onward
// Funct      in   6  IR[5:0]
// Cero       in   1  ALU result == 0 (BEQ compare)
// MemListo   in   1  memory ready: read data valid / write accepted this cycle
// PCEn       out  1  PC load enable
// IorD       out  1  memory address select: 0=PC, 1=ALUOut
// MemRead    out  1  memory read request (held until MemListo)
// MemWrite   out  1  memory write request (held until MemListo)
// IRWrite    out  1  instruction register load
// RegDst     out  1  write register select: 0=rt, 1=rd
// MemtoReg   out  1  write data select: 0=ALUOut, 1=MDR
// RegWrite   out  1  register file write
// ALUSrcA    out  1  0=PC, 1=rs
// ALUSrcB    out  2  00=rt, 01=4, 10=signext imm, 11=signext imm<<2
// PCSrc      out  2  00=ALU result, 01=ALUOut, 10=jump target
// AluOp      out  3  000 AND,001 OR,010 ADD,110 SUB,111 SLT,100 NOR,101 XOR
// Estado     out  4  current state code (debug)
// Excepcion  out  1  high while in TRAP
// BEHAVIOUR
// - States/codes: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC_R6 RWB7 BRANCH8
//   ADDI_EX9 ADDI_WB10 JUMP11 TRAP12. Codes 13-15 unreachable; if entered -> FETCH next cycle.
// - Every output not listed for a state is 0. While reset=1, all outputs are 0.
// - Next-clock effect of reset=1: state=FETCH, wait counter=0, including mid-instruction.
// - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOp=010, PCSrc=00.
//   Same cycle as MemListo=1: IRWrite=1, PCEn=1, next=DECODE. Otherwise stay.
// - DECODE: ALUSrcA=0, ALUSrcB=11, AluOp=010. Next state by Opcode:
//   000000->EXEC_R, 100011/101011->MEMADR, 000100->BRANCH, 001000->ADDI_EX, 000010->JUMP.
//   Any other opcode -> TRAP.
// - MEMADR: ALUSrcA=1, ALUSrcB=10, AluOp=010. Next: MEMRD if LW, MEMWR if SW.
// - MEMRD: IorD=1, MemRead=1; MemListo -> MEMWB, else stay.
// - MEMWB: MemtoReg=1, RegWrite=1, RegDst=0 -> FETCH.
// - MEMWR: IorD=1, MemWrite=1; MemListo -> FETCH, else stay.
// - EXEC_R: ALUSrcA=1, ALUSrcB=00; AluOp from Funct:
//   20->010, 22->110, 24->000, 25->001, 26->101, 27->100, 2A->111.
//   Valid Funct -> RWB. Other Funct -> AluOp=000 and next=TRAP.
// - RWB: RegDst=1, RegWrite=1 -> FETCH.
// - BRANCH: ALUSrcA=1, ALUSrcB=00, AluOp=110, PCSrc=01, PCEn=Cero (same-cycle) -> FETCH.
// - ADDI_EX: ALUSrcA=1, ALUSrcB=10, AluOp=010 -> ADDI_WB. ADDI_WB: RegWrite=1, RegDst=0 -> FETCH.
// - JUMP: PCSrc=10, PCEn=1 -> FETCH.
// - TRAP: Excepcion=1, all strobes 0; stays until reset.
// - Wait counter: counts clocks spent in FETCH/MEMRD/MEMWR with MemListo=0.
//   Clears on MemListo=1 or on leaving the state. If TIMEOUT!=0 and count reaches TIMEOUT-1
//   while MemListo=0 -> TRAP next clock. MemListo on that same cycle wins (normal advance).
// - Strobes are single-cycle except MemRead/MemWrite, which are held through the wait.
// TESTING
// - reset=1 two cycles mid-MEMRD -> all outputs 0 during reset, Estado=0 on first cycle after.
// - R-type ADD: Opcode=0, Funct=0x20, MemListo=1 every cycle -> Estado 0,1,6,7,0;
//   AluOp=010 in EXEC_R; RegWrite=1, RegDst=1 only in RWB.
// - LW with MemListo low 3 cycles in MEMRD -> MemRead,IorD held 4 cycles; then MEMWB with
//   MemtoReg=1, RegWrite=1. Total 5 states + 3 stall = 8 cycles.
// - BEQ: Cero=1 -> PCEn=1, PCSrc=01 in BRANCH; repeat with Cero=0 -> PCEn=0. AluOp=110 both.
// - Funct=0x2A -> AluOp=111; Funct=0x27 -> AluOp=100; Funct=0x3F -> TRAP, Excepcion=1 held.
// - TIMEOUT=4, MemListo=0 in FETCH -> TRAP after 4 FETCH cycles; MemListo=1 on 4th cycle
//   -> DECODE instead.

Source files
------------

// File: rtl/control_multiciclo.sv
// Multicycle MIPS main control FSM.
// Sequences fetch/decode/execute/mem/writeback and drives datapath controls.
module control_multiciclo #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Cero,
  input  logic       MemListo,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] AluOp,
  output logic [3:0] Estado,
  output logic       Excepcion
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIM =
    (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    waiting   = 1'b0;
    PCEn      = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    AluOp     = OP_AND;
    Excepcion = 1'b0;
    Estado    = state_q;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        AluOp   = OP_ADD;
        waiting = 1'b1;
        if (MemListo) begin
          IRWrite = 1'b1;
          PCEn    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        AluOp   = OP_ADD;
        case (Opcode)
          6'b000000: state_d = S_EXEC_R;
          6'b100011: state_d = S_MEMADR;
          6'b101011: state_d = S_MEMADR;
          6'b000100: state_d = S_BRANCH;
          6'b001000: state_d = S_ADDI_EX;
          6'b000010: state_d = S_JUMP;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        AluOp   = OP_ADD;
        case (Opcode)
          6'b100011: state_d = S_MEMRD;
          6'b101011: state_d = S_MEMWR;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        waiting = 1'b1;
        if (MemListo) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        waiting  = 1'b1;
        if (MemListo) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        state_d = S_RWB;
        case (Funct)
          6'h20:   AluOp = OP_ADD;
          6'h22:   AluOp = OP_SUB;
          6'h24:   AluOp = OP_AND;
          6'h25:   AluOp = OP_OR;
          6'h26:   AluOp = OP_XOR;
          6'h27:   AluOp = OP_NOR;
          6'h2A:   AluOp = OP_SLT;
          default: state_d = S_TRAP;
        endcase
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        AluOp   = OP_SUB;
        PCSrc   = 2'b01;
        PCEn    = Cero;
        state_d = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        AluOp   = OP_ADD;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCEn    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        Excepcion = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // A ready on the limit cycle still advances normally
    if (waiting && !MemListo) begin
      if (TIMEOUT != 0 && cnt_q == LIM) begin
        state_d = S_TRAP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (reset) begin
      PCEn      = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      PCSrc     = 2'b00;
      AluOp     = 3'b000;
      Excepcion = 1'b0;
      Estado    = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Scoreboard bench for control_multiciclo (TIMEOUT=4).
// Driver queues hand-computed expectations; monitor checks each cycle.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       Cero, MemListo;
  logic       PCEn, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] AluOp;
  logic [3:0] Estado;
  logic       Excepcion;

  control_multiciclo #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .Cero(Cero), .MemListo(MemListo), .PCEn(PCEn), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .AluOp(AluOp), .Estado(Estado), .Excepcion(Excepcion)
  );

  always #5 clk = ~clk;

  // {PCEn,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,
  //  ALUSrcA,ALUSrcB,PCSrc,AluOp,Excepcion}
  localparam logic [16:0] V_ZERO   = 17'b0_0_0_0_0_0_0_0_0_00_00_000_0;
  localparam logic [16:0] V_FET_W  = 17'b0_0_1_0_0_0_0_0_0_01_00_010_0;
  localparam logic [16:0] V_FET_R  = 17'b1_0_1_0_1_0_0_0_0_01_00_010_0;
  localparam logic [16:0] V_DEC    = 17'b0_0_0_0_0_0_0_0_0_11_00_010_0;
  localparam logic [16:0] V_MADR   = 17'b0_0_0_0_0_0_0_0_1_10_00_010_0;
  localparam logic [16:0] V_MRD    = 17'b0_1_1_0_0_0_0_0_0_00_00_000_0;
  localparam logic [16:0] V_MWB    = 17'b0_0_0_0_0_0_1_1_0_00_00_000_0;
  localparam logic [16:0] V_MWR    = 17'b0_1_0_1_0_0_0_0_0_00_00_000_0;
  localparam logic [16:0] V_EX_ADD = 17'b0_0_0_0_0_0_0_0_1_00_00_010_0;
  localparam logic [16:0] V_EX_SLT = 17'b0_0_0_0_0_0_0_0_1_00_00_111_0;
  localparam logic [16:0] V_EX_NOR = 17'b0_0_0_0_0_0_0_0_1_00_00_100_0;
  localparam logic [16:0] V_EX_BAD = 17'b0_0_0_0_0_0_0_0_1_00_00_000_0;
  localparam logic [16:0] V_RWB    = 17'b0_0_0_0_0_1_0_1_0_00_00_000_0;
  localparam logic [16:0] V_BR_T   = 17'b1_0_0_0_0_0_0_0_1_00_01_110_0;
  localparam logic [16:0] V_BR_N   = 17'b0_0_0_0_0_0_0_0_1_00_01_110_0;
  localparam logic [16:0] V_AEX    = 17'b0_0_0_0_0_0_0_0_1_10_00_010_0;
  localparam logic [16:0] V_AWB    = 17'b0_0_0_0_0_0_0_1_0_00_00_000_0;
  localparam logic [16:0] V_JMP    = 17'b1_0_0_0_0_0_0_0_0_00_10_000_0;
  localparam logic [16:0] V_TRAP   = 17'b0_0_0_0_0_0_0_0_0_00_00_000_1;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;

  typedef struct {
    string       nm;
    logic [3:0]  est;
    logic [16:0] v;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [16:0] act;
      e = q.pop_front();
      act = {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
             RegWrite, ALUSrcA, ALUSrcB, PCSrc, AluOp, Excepcion};
      n_chk++;
      if (act === e.v && Estado === e.est) n_pass++;
      else $display("FAIL %s: Estado=%0d outs=%b, expected Estado=%0d outs=%b",
                    e.nm, Estado, act, e.est, e.v);
    end
  end

  task automatic st(input string nm, input logic r, input logic [5:0] op,
                    input logic [5:0] fn, input logic c, input logic ml,
                    input logic [3:0] est, input logic [16:0] v);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; Opcode = op; Funct = fn; Cero = c; MemListo = ml;
    e.nm = nm; e.est = est; e.v = v;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; Opcode = '0; Funct = '0; Cero = 1'b0; MemListo = 1'b0;
    st("rst0", 1, OP_R, 6'h20, 0, 0, 0, V_ZERO);
    st("rst1", 1, OP_R, 6'h20, 0, 0, 0, V_ZERO);
    // R-type ADD
    st("add_fetch", 0, OP_R, 6'h20, 0, 1, 0, V_FET_R);
    st("add_dec",   0, OP_R, 6'h20, 0, 1, 1, V_DEC);
    st("add_ex",    0, OP_R, 6'h20, 0, 1, 6, V_EX_ADD);
    st("add_rwb",   0, OP_R, 6'h20, 0, 1, 7, V_RWB);
    // LW with 3 stall cycles in MEMRD
    st("lw_fetch",  0, OP_LW, 6'h00, 0, 1, 0, V_FET_R);
    st("lw_dec",    0, OP_LW, 6'h00, 0, 1, 1, V_DEC);
    st("lw_madr",   0, OP_LW, 6'h00, 0, 1, 2, V_MADR);
    st("lw_rd_w1",  0, OP_LW, 6'h00, 0, 0, 3, V_MRD);
    st("lw_rd_w2",  0, OP_LW, 6'h00, 0, 0, 3, V_MRD);
    st("lw_rd_w3",  0, OP_LW, 6'h00, 0, 0, 3, V_MRD);
    st("lw_rd_ok",  0, OP_LW, 6'h00, 0, 1, 3, V_MRD);
    st("lw_wb",     0, OP_LW, 6'h00, 0, 1, 4, V_MWB);
    // SW with one stall
    st("sw_fetch",  0, OP_SW, 6'h00, 0, 1, 0, V_FET_R);
    st("sw_dec",    0, OP_SW, 6'h00, 0, 1, 1, V_DEC);
    st("sw_madr",   0, OP_SW, 6'h00, 0, 1, 2, V_MADR);
    st("sw_wr_w",   0, OP_SW, 6'h00, 0, 0, 5, V_MWR);
    st("sw_wr_ok",  0, OP_SW, 6'h00, 0, 1, 5, V_MWR);
    // BEQ taken / not taken
    st("beq_fetch", 0, OP_BEQ, 6'h00, 1, 1, 0, V_FET_R);
    st("beq_dec",   0, OP_BEQ, 6'h00, 1, 1, 1, V_DEC);
    st("beq_t",     0, OP_BEQ, 6'h00, 1, 1, 8, V_BR_T);
    st("beq_fetch2",0, OP_BEQ, 6'h00, 0, 1, 0, V_FET_R);
    st("beq_dec2",  0, OP_BEQ, 6'h00, 0, 1, 1, V_DEC);
    st("beq_nt",    0, OP_BEQ, 6'h00, 0, 1, 8, V_BR_N);
    // ADDI and J
    st("addi_fetch",0, OP_ADDI, 6'h00, 0, 1, 0, V_FET_R);
    st("addi_dec",  0, OP_ADDI, 6'h00, 0, 1, 1, V_DEC);
    st("addi_ex",   0, OP_ADDI, 6'h00, 0, 1, 9, V_AEX);
    st("addi_wb",   0, OP_ADDI, 6'h00, 0, 1, 10, V_AWB);
    st("j_fetch",   0, OP_J, 6'h00, 0, 1, 0, V_FET_R);
    st("j_dec",     0, OP_J, 6'h00, 0, 1, 1, V_DEC);
    st("j_jump",    0, OP_J, 6'h00, 0, 1, 11, V_JMP);
    // SLT and NOR funct decode
    st("slt_fetch", 0, OP_R, 6'h2A, 0, 1, 0, V_FET_R);
    st("slt_dec",   0, OP_R, 6'h2A, 0, 1, 1, V_DEC);
    st("slt_ex",    0, OP_R, 6'h2A, 0, 1, 6, V_EX_SLT);
    st("slt_rwb",   0, OP_R, 6'h2A, 0, 1, 7, V_RWB);
    st("nor_fetch", 0, OP_R, 6'h27, 0, 1, 0, V_FET_R);
    st("nor_dec",   0, OP_R, 6'h27, 0, 1, 1, V_DEC);
    st("nor_ex",    0, OP_R, 6'h27, 0, 1, 6, V_EX_NOR);
    st("nor_rwb",   0, OP_R, 6'h27, 0, 1, 7, V_RWB);
    // Illegal funct -> TRAP held
    st("bad_fetch", 0, OP_R, 6'h3F, 0, 1, 0, V_FET_R);
    st("bad_dec",   0, OP_R, 6'h3F, 0, 1, 1, V_DEC);
    st("bad_ex",    0, OP_R, 6'h3F, 0, 1, 6, V_EX_BAD);
    st("trap1",     0, OP_R, 6'h3F, 0, 1, 12, V_TRAP);
    st("trap2",     0, OP_R, 6'h3F, 0, 1, 12, V_TRAP);
    st("trap3",     0, OP_R, 6'h3F, 0, 0, 12, V_TRAP);
    st("trap_rst",  1, OP_R, 6'h3F, 0, 0, 0, V_ZERO);
    // Illegal opcode -> TRAP
    st("bop_fetch", 0, 6'h3F, 6'h00, 0, 1, 0, V_FET_R);
    st("bop_dec",   0, 6'h3F, 6'h00, 0, 1, 1, V_DEC);
    st("bop_trap",  0, 6'h3F, 6'h00, 0, 1, 12, V_TRAP);
    // Reset for two cycles in the middle of MEMRD
    st("mr_rst0",   1, OP_LW, 6'h00, 0, 1, 0, V_ZERO);
    st("mr_fetch",  0, OP_LW, 6'h00, 0, 1, 0, V_FET_R);
    st("mr_dec",    0, OP_LW, 6'h00, 0, 1, 1, V_DEC);
    st("mr_madr",   0, OP_LW, 6'h00, 0, 1, 2, V_MADR);
    st("mr_rd",     0, OP_LW, 6'h00, 0, 0, 3, V_MRD);
    st("mr_rstA",   1, OP_LW, 6'h00, 0, 0, 0, V_ZERO);
    st("mr_rstB",   1, OP_LW, 6'h00, 0, 0, 0, V_ZERO);
    st("mr_after",  0, OP_LW, 6'h00, 0, 0, 0, V_FET_W);
    st("mr_after2", 0, OP_LW, 6'h00, 0, 1, 0, V_FET_R);
    st("mr_dec2",   0, OP_LW, 6'h00, 0, 1, 1, V_DEC);
    // Timeout: 4 FETCH cycles with no ready -> TRAP
    st("to_rst",    1, OP_R, 6'h20, 0, 0, 0, V_ZERO);
    st("to_f1",     0, OP_R, 6'h20, 0, 0, 0, V_FET_W);
    st("to_f2",     0, OP_R, 6'h20, 0, 0, 0, V_FET_W);
    st("to_f3",     0, OP_R, 6'h20, 0, 0, 0, V_FET_W);
    st("to_f4",     0, OP_R, 6'h20, 0, 0, 0, V_FET_W);
    st("to_trap",   0, OP_R, 6'h20, 0, 0, 12, V_TRAP);
    // Ready on the limit cycle wins
    st("tw_rst",    1, OP_R, 6'h20, 0, 0, 0, V_ZERO);
    st("tw_f1",     0, OP_R, 6'h20, 0, 0, 0, V_FET_W);
    st("tw_f2",     0, OP_R, 6'h20, 0, 0, 0, V_FET_W);
    st("tw_f3",     0, OP_R, 6'h20, 0, 0, 0, V_FET_W);
    st("tw_f4",     0, OP_R, 6'h20, 0, 1, 0, V_FET_R);
    st("tw_dec",    0, OP_R, 6'h20, 0, 1, 1, V_DEC);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d pending, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
